// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO drain path: default word width, packer
// states and the lane-counter width helper.
package fifo_pkg;

    localparam int unsigned DEF_BITS = 12;

    typedef enum logic {
        COLLECT = 1'b0,
        OUTPUT  = 1'b1
    } state_e;

    // Counter must hold 0..pack inclusive.
    function automatic int unsigned cnt_w(input int unsigned pack);
        return $clog2(pack + 1);
    endfunction

endpackage

// File: rtl/sat_edge_counter.sv
// Counts 0->1 transitions of a level input, saturating at all-ones.
// A synchronous clear wins over a same-cycle increment.
module sat_edge_counter #(
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in,
    input  logic             clr,
    output logic [ERR_W-1:0] cnt
);

    logic             prev_q, prev_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        prev_d = in;
        cnt_d  = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (in && !prev_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/fifo_word_packer.sv
// Drains the SRAM FIFO, packs PACK words (or a flushed partial set) into one
// wide beat for a valid/ready consumer, and counts FIFO overflow events.
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter  int unsigned BITS  = DEF_BITS,
    parameter  int unsigned PACK  = 4,
    parameter  int unsigned ERR_W = 8,
    localparam int unsigned CNT_W = cnt_w(PACK)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fifo_ready,
    input  logic [BITS-1:0]      fifo_data,
    input  logic                 fifo_overflow,
    output logic                 fifo_read,
    input  logic                 flush,
    output logic [PACK*BITS-1:0] out_data,
    output logic [CNT_W-1:0]     out_count,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 ovf_clr,
    output logic [ERR_W-1:0]     ovf_cnt
);

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [CNT_W-1:0]          out_count_q, out_count_d;
    logic                      out_valid_q, out_valid_d;
    logic [PACK-1:0][BITS-1:0] lane_q, lane_d;
    logic                      pop_c;

    // Next-state: fill lanes in pop order, hold the beat until accepted.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        out_count_d = out_count_q;
        out_valid_d = out_valid_q;
        lane_d      = lane_q;
        pop_c       = 1'b0;
        case (state_q)
            COLLECT: begin
                pop_c = fifo_ready & ~flush;
                if (pop_c) begin
                    for (int i = 0; i < int'(PACK); i++) begin
                        if (count_q == CNT_W'(i)) begin
                            lane_d[i] = fifo_data;
                        end
                    end
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(PACK - 1)) begin
                        state_d     = OUTPUT;
                        out_valid_d = 1'b1;
                        out_count_d = CNT_W'(PACK);
                    end
                end else if (flush && (count_q != '0)) begin
                    state_d     = OUTPUT;
                    out_valid_d = 1'b1;
                    out_count_d = count_q;
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    state_d     = COLLECT;
                    count_d     = '0;
                    lane_d      = '0;
                    out_count_d = '0;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            count_q     <= '0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            out_count_q <= out_count_d;
            out_valid_q <= out_valid_d;
        end
    end

    for (genvar g = 0; g < int'(PACK); g++) begin : g_lane
        logic [BITS-1:0] word_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                word_q <= '0;
            end else begin
                word_q <= lane_d[g];
            end
        end

        assign lane_q[g] = word_q;
    end

    sat_edge_counter #(
        .ERR_W (ERR_W)
    ) u_ovf_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (fifo_overflow),
        .clr   (ovf_clr),
        .cnt   (ovf_cnt)
    );

    assign fifo_read = pop_c;
    assign out_data  = lane_q;
    assign out_count = out_count_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: queue-based FIFO and packing model, scoreboard
// of expected beats drained by an independent output monitor.
module tb_fifo_word_packer;

    localparam int unsigned BITS  = 12;
    localparam int unsigned PACK  = 4;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned ERR_W = 8;
    localparam int unsigned W     = PACK * BITS;

    logic             clk;
    logic             rst_n;
    logic             fifo_ready;
    logic [BITS-1:0]  fifo_data;
    logic             fifo_overflow;
    logic             fifo_read;
    logic             flush;
    logic [W-1:0]     out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_valid;
    logic             out_ready;
    logic             ovf_clr;
    logic [ERR_W-1:0] ovf_cnt;

    fifo_word_packer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fifo_ready    (fifo_ready),
        .fifo_data     (fifo_data),
        .fifo_overflow (fifo_overflow),
        .fifo_read     (fifo_read),
        .flush         (flush),
        .out_data      (out_data),
        .out_count     (out_count),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .ovf_clr       (ovf_clr),
        .ovf_cnt       (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]     data;
        logic [CNT_W-1:0] cnt;
    } beat_t;

    beat_t           sb_q[$];
    logic [BITS-1:0] fifo_q[$];
    logic [BITS-1:0] acc_q[$];
    bit              pending;
    int              ovf_model;
    bit              ovf_prev;
    int              errors;
    int              checks;
    int              dut_pops;
    int              beats_seen;
    logic [W-1:0]     last_beat;
    logic [CNT_W-1:0] last_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference packing: lane i holds the i-th word popped since the last beat.
    task automatic form_beat();
        beat_t b;
        b.data = '0;
        for (int i = 0; i < acc_q.size(); i++) begin
            b.data[i*BITS +: BITS] = acc_q[i];
        end
        b.cnt = CNT_W'(acc_q.size());
        sb_q.push_back(b);
        acc_q.delete();
        pending = 1'b1;
    endtask

    task automatic cyc(input bit en, input bit fl, input bit ordy, input bit ovf, input bit clr);
        bit exp_pop;
        @(negedge clk);
        fifo_ready    = en && (fifo_q.size() > 0);
        fifo_data     = fifo_ready ? fifo_q[0] : BITS'($urandom);
        flush         = fl;
        out_ready     = ordy;
        fifo_overflow = ovf;
        ovf_clr       = clr;
        #1;
        chk("ovf_cnt", 64'(ovf_cnt), 64'(ovf_model));
        chk("out_valid", 64'(out_valid), 64'(pending));
        exp_pop = !pending && fifo_ready && !fl;
        chk("fifo_read", 64'(fifo_read), 64'(exp_pop));
        if (fifo_read) dut_pops++;
        if (pending) begin
            if (ordy) pending = 1'b0;
        end else if (exp_pop) begin
            acc_q.push_back(fifo_q.pop_front());
            if (acc_q.size() == PACK) form_beat();
        end else if (fl && acc_q.size() > 0) begin
            form_beat();
        end
        if (clr) ovf_model = 0;
        else if (ovf && !ovf_prev && ovf_model < 255) ovf_model++;
        ovf_prev = ovf;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_data"},  64'(out_data),  64'(0));
        chk({tag, "_count"}, 64'(out_count), 64'(0));
        chk({tag, "_ovf"},   64'(ovf_cnt),   64'(0));
    endtask

    // Monitor: every presented beat must match the scoreboard head.
    always @(negedge clk) begin
        #2;
        if (rst_n && out_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_beat", 64'(1), 64'(0));
            end else begin
                chk("out_data", 64'(out_data), 64'(sb_q[0].data));
                chk("out_count", 64'(out_count), 64'(sb_q[0].cnt));
                if (out_ready) begin
                    last_beat = out_data;
                    last_cnt  = out_count;
                    beats_seen++;
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        int p0;
        int b0;
        errors = 0; checks = 0; dut_pops = 0; beats_seen = 0;
        pending = 1'b0; ovf_model = 0; ovf_prev = 1'b0;
        last_beat = '0; last_cnt = '0;
        rst_n = 1'b0; fifo_ready = 1'b0; fifo_data = '0; fifo_overflow = 1'b0;
        flush = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
        #12;
        chk_zero_outputs("reset");
        #10 rst_n = 1'b1;

        // Full beat, consumer always ready.
        for (int i = 1; i <= 4; i++) fifo_q.push_back(BITS'(i));
        p0 = dut_pops; b0 = beats_seen;
        repeat (8) cyc(1, 0, 1, 0, 0);
        chk("t1_pops", 64'(dut_pops - p0), 64'(4));
        chk("t1_beats", 64'(beats_seen - b0), 64'(1));
        chk("t1_data", 64'(last_beat), 64'h004003002001);
        chk("t1_count", 64'(last_cnt), 64'(4));

        // Back-pressure: beat held, remaining FIFO words untouched.
        for (int i = 0; i < 7; i++) fifo_q.push_back(BITS'(12'h010 + i));
        p0 = dut_pops;
        repeat (14) cyc(1, 0, 0, 0, 0);
        chk("t2_pops", 64'(dut_pops - p0), 64'(4));
        chk("t2_held_valid", 64'(out_valid), 64'(1));
        chk("t2_held_data", 64'(out_data), 64'h013012011010);
        repeat (5) cyc(1, 0, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        repeat (3) cyc(0, 0, 1, 0, 0);
        chk("t2_tail", 64'(last_beat), 64'h000016015014);

        // Partial beat by flush, then a flush with nothing collected.
        fifo_q.push_back(12'hABC);
        fifo_q.push_back(12'h123);
        repeat (3) cyc(1, 0, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        repeat (3) cyc(0, 0, 1, 0, 0);
        chk("t3_data", 64'(last_beat), 64'h000000123ABC);
        chk("t3_count", 64'(last_cnt), 64'(2));
        b0 = beats_seen;
        repeat (4) cyc(1, 1, 1, 0, 0);
        chk("t3_empty_flush", 64'(beats_seen - b0), 64'(0));

        // Overflow edge counting, saturation and clear priority.
        cyc(0, 0, 1, 0, 1);
        cyc(0, 0, 1, 1, 0);
        repeat (2) cyc(0, 0, 1, 0, 0);
        repeat (5) cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("t4_three", 64'(ovf_cnt), 64'(3));
        repeat (300) begin
            cyc(0, 0, 1, 1, 0);
            cyc(0, 0, 1, 0, 0);
        end
        chk("t4_sat", 64'(ovf_cnt), 64'(255));
        cyc(0, 0, 1, 1, 1);
        cyc(0, 0, 1, 0, 0);
        chk("t4_clr", 64'(ovf_cnt), 64'(0));

        // Asynchronous reset with a partial beat in flight.
        cyc(0, 0, 1, 1, 0);
        for (int i = 5; i <= 7; i++) fifo_q.push_back(BITS'(i));
        for (int i = 10; i <= 13; i++) fifo_q.push_back(BITS'(i));
        repeat (3) cyc(1, 0, 1, 0, 0);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        fifo_ready = 1'b0;
        fifo_overflow = 1'b0;
        #1;
        chk_zero_outputs("async_rst");
        acc_q.delete(); sb_q.delete();
        pending = 1'b0; ovf_model = 0; ovf_prev = 1'b0;
        @(negedge clk);
        #3 rst_n = 1'b1;
        repeat (8) cyc(1, 0, 1, 0, 0);
        chk("t5_data", 64'(last_beat), 64'h00D00C00B00A);

        // FIFO ready toggling every cycle.
        for (int i = 1; i <= 4; i++) fifo_q.push_back(BITS'(12'h111 * i));
        for (int i = 0; i < 12; i++) cyc((i % 2) == 0, 0, 1, 0, 0);
        chk("t6_data", 64'(last_beat), 64'h444333222111);

        // Randomized traffic against the model.
        repeat (3000) begin
            if (fifo_q.size() < 8 && $urandom_range(1, 0) == 1) fifo_q.push_back(BITS'($urandom));
            cyc($urandom_range(3, 0) != 0, $urandom_range(15, 0) == 0,
                $urandom_range(2, 0) != 0, $urandom_range(7, 0) == 0,
                $urandom_range(63, 0) == 0);
        end
        repeat (20) cyc(1, 0, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        repeat (4) cyc(0, 0, 1, 0, 0);
        chk("drain_sb_empty", 64'(sb_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
